// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sequencer and busy scoreboard
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
);
  localparam logic CLEAR = 1'b0;
  localparam logic RUN = 1'b1;
  logic             state;
  logic [AW-1:0]    clr_idx;
  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  assign ready = state == RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
      if (clr_idx == AW'(NREGS - 1)) state <= RUN;
    end
  // later ports overwrite earlier ones, so the highest-index port wins a collision
  always_ff @(posedge clk)
    if (!ready) mem[clr_idx] <= '0;
    else
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0))
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
  // reserve is applied after the write-clears so a new producer keeps the register busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else if (ready) begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j]) busy[wr_addr[j*AW +: AW]] <= 1'b0;
      if (rsv_en && !(ZERO_REG != 0 && rsv_addr == '0)) busy[rsv_addr] <= 1'b1;
    end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++)
      if (ready && !(ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0)) begin
        rd_busy[i] = busy[rd_addr[i*AW +: AW]];
        rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
        for (int j = 0; j < NWR; j++)
          if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
      end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  logic        clk = 0, rst_n = 1;
  logic        ready, ready2;
  logic [9:0]  rd_addr = '0, wr_addr = '0;
  logic [63:0] rd_data, wr_data = '0;
  logic [1:0]  rd_busy, wr_en = '0;
  logic        rsv_en = 0;
  logic [4:0]  rsv_addr = '0;
  logic [2:0]  rd_addr2 = '0, wr_addr2 = '0, rsv_addr2 = '0;
  logic [31:0] rd_data2, wr_data2 = '0;
  logic        rd_busy2, wr_en2 = 0, rsv_en2 = 0;
  int n_cmp = 0, n_bad = 0, cnt = 0;
  bit en = 0;
  logic [31:0] m [32];
  bit b [32];

  regfile_mp #(.NRD(2), .NWR(2)) u (
    .clk(clk), .rst_n(rst_n), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr));

  regfile_mp #(.NREGS(8), .NRD(1), .NWR(1), .ZERO_REG(0), .BYPASS(0)) u2 (
    .clk(clk), .rst_n(rst_n), .ready(ready2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_busy(rd_busy2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rsv_en(rsv_en2), .rsv_addr(rsv_addr2));

  always #10 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: ready after 32 edges, then the file is all zeros
  always @(negedge rst_n) begin
    cnt = 0;
    foreach (b[k]) b[k] = 0;
  end
  always @(posedge clk) begin
    int a;
    if (rst_n) begin
      if (cnt < 32) begin
        cnt++;
        if (cnt == 32) foreach (m[k]) m[k] = '0;
      end else begin
        for (int j = 0; j < 2; j++)
          if (wr_en[j]) begin
            a = int'(wr_addr[j*5 +: 5]);
            if (a != 0) m[a] = wr_data[j*32 +: 32];
            b[a] = 0;
          end
        if (rsv_en && rsv_addr != 0) b[rsv_addr] = 1;
      end
    end
  end

  function automatic logic [31:0] exp_rd(int a);
    logic [31:0] r;
    if (cnt < 32 || a == 0) return '0;
    r = m[a];
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && int'(wr_addr[j*5 +: 5]) == a) r = wr_data[j*32 +: 32];
    return r;
  endfunction

  always @(negedge clk)
    if (en && rst_n) begin
      chk("ready", {31'd0, ready}, (cnt >= 32) ? 32'd1 : 32'd0);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rd_data%0d", i), rd_data[i*32 +: 32], exp_rd(int'(rd_addr[i*5 +: 5])));
        chk($sformatf("rd_busy%0d", i), {31'd0, rd_busy[i]},
            (cnt >= 32 && b[rd_addr[i*5 +: 5]]) ? 32'd1 : 32'd0);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rsv_en = 0; wr_en2 = 0; rsv_en2 = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    en = 1;
    #25;
    step();
    rst_n = 1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #2;
      chk("t1_ready", {31'd0, ready}, (i >= 32) ? 32'd1 : 32'd0);
      chk("t1_ready2", {31'd0, ready2}, (i >= 8) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 32; a++) begin
      step();
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("t1_zero", rd_data[31:0], 32'h0);
      chk("t1_notbusy", {30'd0, rd_busy}, 32'h0);
    end
    step();
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF; rd_addr[4:0] = 5'd5;
    wr_en2 = 1; wr_addr2 = 3'd5; wr_data2 = 32'hDEADBEEF; rd_addr2 = 3'd5;
    #1;
    chk("t2_bypass", rd_data[31:0], 32'hDEADBEEF);
    chk("t2_nobypass", rd_data2, 32'h0);
    step();
    idle();
    #1;
    chk("t2_hold", rd_data[31:0], 32'hDEADBEEF);
    chk("t2_hold2", rd_data2, 32'hDEADBEEF);
    step();
    wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'h1234; rsv_en = 1; rsv_addr = 5'd0;
    rd_addr[4:0] = 5'd0;
    wr_en2 = 1; wr_addr2 = 3'd0; wr_data2 = 32'h1234; rsv_en2 = 1; rsv_addr2 = 3'd0; rd_addr2 = 3'd0;
    #1;
    chk("t3_r0_same", rd_data[31:0], 32'h0);
    step();
    idle();
    #1;
    chk("t3_r0", rd_data[31:0], 32'h0);
    chk("t3_r0_busy", {31'd0, rd_busy[0]}, 32'h0);
    chk("t3_u2_r0", rd_data2, 32'h1234);
    chk("t3_u2_busy", {31'd0, rd_busy2}, 32'h1);
    step();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr[9:5] = 5'd7;
    #1;
    chk("t4_same", rd_data[63:32], 32'h22);
    step();
    idle();
    #1;
    chk("t4_next", rd_data[63:32], 32'h22);
    step();
    rsv_en = 1; rsv_addr = 5'd3; rd_addr[4:0] = 5'd3;
    #1;
    chk("t5_busy_pre", {31'd0, rd_busy[0]}, 32'h0);
    step();
    idle();
    #1;
    chk("t5_busy_set", {31'd0, rd_busy[0]}, 32'h1);
    step();
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h9; rsv_en = 1; rsv_addr = 5'd3;
    step();
    idle();
    #1;
    chk("t5_busy_keep", {31'd0, rd_busy[0]}, 32'h1);
    chk("t5_data9", rd_data[31:0], 32'h9);
    step();
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h10;
    #1;
    chk("t5_busy_reg", {31'd0, rd_busy[0]}, 32'h1);
    step();
    idle();
    #1;
    chk("t5_busy_clr", {31'd0, rd_busy[0]}, 32'h0);
    chk("t5_data10", rd_data[31:0], 32'h10);
    step();
    wr_en = 2'b01; wr_addr[4:0] = 5'd1; wr_data[31:0] = 32'hAA;
    step();
    wr_en = '0; rsv_en = 1; rsv_addr = 5'd2;
    step();
    idle();
    rd_addr = {5'd2, 5'd1};
    #1;
    chk("t6_r1", rd_data[31:0], 32'hAA);
    chk("t6_busy_pre", {31'd0, rd_busy[1]}, 32'h1);
    #1 rst_n = 0;
    #1;
    chk("t6_ready_drop", {31'd0, ready}, 32'h0);
    chk("t6_busy_drop", {31'd0, rd_busy[1]}, 32'h0);
    #2 rst_n = 1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("t6_ready", {31'd0, ready}, (k >= 32) ? 32'd1 : 32'd0);
      if (k < 32) begin
        wr_en = 2'b11; wr_addr = {5'd1, 5'd1}; wr_data = {$urandom, $urandom};
        rsv_en = 1; rsv_addr = 5'd1;
      end else idle();
    end
    #1;
    chk("t6_r1_cleared", rd_data[31:0], 32'h0);
    chk("t6_r1_notbusy", {31'd0, rd_busy[0]}, 32'h0);
    repeat (1500) begin
      step();
      wr_en = 2'($urandom);
      for (int j = 0; j < 2; j++) begin
        wr_addr[j*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        rd_addr[j*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wr_data[j*32 +: 32] = $urandom;
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
    end
    step();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
